// File: rtl/motor_pwm_driver.sv
// motor_pwm_driver: two-wheel H-bridge PWM driver with soft-start ramping,
// brake-before-reverse dead time and period-aligned duty updates.
module motor_pwm_driver #(
  parameter int PWM_PERIOD = 1000,
  parameter int DUTY_FWD   = 700,
  parameter int DUTY_TURN  = 500,
  parameter int RAMP_STEP  = 10,
  parameter int RAMP_DIV   = 5000,
  parameter int DEADTIME   = 2500
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [4:0] motor_state,
  input  logic       overwrite,
  output logic       left_pwm,
  output logic       right_pwm,
  output logic       left_dir,
  output logic       right_dir,
  output logic       moving,
  output logic       cmd_err
);
  localparam int DW = $clog2(PWM_PERIOD + 1);
  localparam int PW = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;
  localparam int RW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int TW = $clog2(DEADTIME + 1);
  localparam logic [DW-1:0] D_FWD  = DW'(DUTY_FWD);
  localparam logic [DW-1:0] D_TURN = DW'(DUTY_TURN);
  localparam logic [DW-1:0] D_STEP = DW'(RAMP_STEP);
  localparam logic [PW-1:0] P_LAST = PW'(PWM_PERIOD - 1);
  localparam logic [RW-1:0] R_LAST = RW'(RAMP_DIV - 1);
  localparam logic [TW-1:0] T_LAST = TW'(DEADTIME - 1);
  localparam logic [4:0]    C_STOP = 5'b00001;

  typedef enum logic [1:0] {IDLE, RAMP, BRAKE, DEAD} wheel_e;

  logic [4:0]    cmd_q;
  logic          err_q;
  logic          cmd_ok;
  logic [PW-1:0] pcnt_q;
  logic [RW-1:0] rcnt_q;
  logic          tick;
  logic          wrap;
  wheel_e        st_q   [2];
  wheel_e        st_d   [2];
  logic [DW-1:0] duty_q [2];
  logic [DW-1:0] duty_d [2];
  logic [DW-1:0] app_q  [2];
  logic [DW-1:0] app_d  [2];
  logic [DW-1:0] tduty  [2];
  logic [TW-1:0] dcnt_q [2];
  logic [TW-1:0] dcnt_d [2];
  logic          dir_q  [2];
  logic          dir_d  [2];
  logic          tdir   [2];
  logic          pwm_q  [2];
  logic          mov_q;

  function automatic logic [DW-1:0] step_to(
    input logic [DW-1:0] cur,
    input logic [DW-1:0] tgt
  );
    if (tgt > cur)
      return (tgt - cur < D_STEP) ? tgt : cur + D_STEP;
    else
      return (cur - tgt < D_STEP) ? tgt : cur - D_STEP;
  endfunction

  assign cmd_ok = (motor_state != 5'd0) &&
                  ((motor_state & (motor_state - 5'd1)) == 5'd0);
  assign tick   = (rcnt_q == R_LAST);
  assign wrap   = (pcnt_q == P_LAST);

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      cmd_q  <= C_STOP;
      err_q  <= 1'b0;
      pcnt_q <= '0;
      rcnt_q <= '0;
    end else begin
      cmd_q  <= cmd_ok ? motor_state : C_STOP;
      err_q  <= !cmd_ok;
      pcnt_q <= wrap ? '0 : pcnt_q + 1'b1;
      rcnt_q <= tick ? '0 : rcnt_q + 1'b1;
    end
  end

  // STOP keeps each wheel's current direction so it never triggers a brake
  always_comb begin
    tdir[0]  = dir_q[0];
    tdir[1]  = dir_q[1];
    tduty[0] = '0;
    tduty[1] = '0;
    unique case (1'b1)
      cmd_q[0]: ;
      cmd_q[1]: begin
        tdir[0]  = 1'b1;  tdir[1]  = 1'b1;
        tduty[0] = D_FWD; tduty[1] = D_FWD;
      end
      cmd_q[2]: begin
        tdir[0]  = 1'b0;   tdir[1]  = 1'b1;
        tduty[0] = D_TURN; tduty[1] = D_TURN;
      end
      cmd_q[3]: begin
        tdir[0]  = 1'b1;   tdir[1]  = 1'b0;
        tduty[0] = D_TURN; tduty[1] = D_TURN;
      end
      cmd_q[4]: begin
        tdir[0]  = 1'b0;  tdir[1]  = 1'b0;
        tduty[0] = D_FWD; tduty[1] = D_FWD;
      end
      default: ;
    endcase
  end

  always_comb begin
    for (int w = 0; w < 2; w++) begin
      st_d[w]   = st_q[w];
      duty_d[w] = duty_q[w];
      dir_d[w]  = dir_q[w];
      dcnt_d[w] = dcnt_q[w];
      unique case (st_q[w])
        IDLE: begin
          duty_d[w] = '0;
          if (tduty[w] != '0) begin
            st_d[w]   = (tdir[w] == dir_q[w]) ? RAMP : DEAD;
            dcnt_d[w] = '0;
          end
        end
        RAMP: begin
          if (tdir[w] != dir_q[w])
            st_d[w] = BRAKE;
          else if (duty_q[w] == '0 && tduty[w] == '0)
            st_d[w] = IDLE;
          else if (tick)
            duty_d[w] = step_to(duty_q[w], tduty[w]);
        end
        BRAKE: begin
          if (duty_q[w] == '0) begin
            st_d[w]   = DEAD;
            dcnt_d[w] = '0;
          end else if (tick) begin
            duty_d[w] = step_to(duty_q[w], '0);
          end
        end
        DEAD: begin
          duty_d[w] = '0;
          // dead time only counts once the applied duty has really reached 0
          if (app_q[w] != '0) begin
            dcnt_d[w] = '0;
          end else if (dcnt_q[w] == T_LAST) begin
            dir_d[w]  = tdir[w];
            st_d[w]   = (tduty[w] != '0) ? RAMP : IDLE;
            dcnt_d[w] = '0;
          end else begin
            dcnt_d[w] = dcnt_q[w] + 1'b1;
          end
        end
        default: st_d[w] = IDLE;
      endcase
      if (overwrite) begin
        st_d[w]   = IDLE;
        duty_d[w] = '0;
        dcnt_d[w] = '0;
      end
      app_d[w] = overwrite ? '0 : (wrap ? duty_q[w] : app_q[w]);
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      for (int w = 0; w < 2; w++) begin
        st_q[w]   <= IDLE;
        duty_q[w] <= '0;
        dir_q[w]  <= 1'b1;
        dcnt_q[w] <= '0;
        app_q[w]  <= '0;
        pwm_q[w]  <= 1'b0;
      end
      mov_q <= 1'b0;
    end else begin
      for (int w = 0; w < 2; w++) begin
        st_q[w]   <= st_d[w];
        duty_q[w] <= duty_d[w];
        dir_q[w]  <= dir_d[w];
        dcnt_q[w] <= dcnt_d[w];
        app_q[w]  <= app_d[w];
        pwm_q[w]  <= !overwrite && (DW'(pcnt_q) < app_q[w]);
      end
      mov_q <= (app_d[0] != '0) || (app_d[1] != '0);
    end
  end

  assign left_pwm  = pwm_q[0];
  assign right_pwm = pwm_q[1];
  assign left_dir  = dir_q[0];
  assign right_dir = dir_q[1];
  assign moving    = mov_q;
  assign cmd_err   = err_q;

endmodule
